median_drift_monitor: RTL and testbench
=======================================

// Module: median_drift_monitor
// PURPOSE
//  Downstream consumer of median_calc. Captures each median result on its data_vld
//  pulse, compares it to a stored baseline median, flags results that deviate by more
//  than a runtime threshold, and raises a sticky alarm after CONSEC consecutive flagged
//  results. Every result becomes a record {median, delta, flag} in a small FIFO drained
//  by a valid/ready handshake toward logging or UART logic.
// PARAMETERS
//  DATA_WIDTH  8  width of median, delta and threshold
//  CONSEC      3  consecutive flagged results needed to raise alarm (>=1)
//  FIFO_DEPTH  4  record FIFO depth (power of 2, >=2)
// PORTS
//  clk         in   1             system clock, rising edge
//  rst         in   1             synchronous, active-high reset
//  median_in   in   DATA_WIDTH    median from median_calc (unsigned)
//  median_vld  in   1             one-cycle pulse: median_in valid this cycle
//  thresh      in   DATA_WIDTH    deviation threshold, sampled on median_vld
//  rebase      in   1             one-cycle pulse: discard baseline, clear streak/alarm
//  out_median  out  DATA_WIDTH    FIFO head: captured median
//  out_delta   out  DATA_WIDTH    FIFO head: |median - baseline|
//  out_flag    out  1             FIFO head: delta > thresh
//  out_valid   out  1             FIFO non-empty
//  out_ready   in   1             consumer accepts head when out_valid & out_ready
//  alarm       out  1             sticky drift alarm
//  overflow    out  1             sticky: a record was dropped because FIFO was full
//  fifo_count  out  $clog2(FIFO_DEPTH)+1  records held
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, streak 0, baseline 0, state NO_BASE.
//    Reset mid-operation discards FIFO contents and baseline.
//  - States:
//    NO_BASE: on median_vld, baseline <= median_in; push {median_in, 0, 0}; go TRACK.
//    TRACK: on median_vld, compute delta and flag; push the record.
//      flag=1: streak++ (saturate at CONSEC). flag=0: streak <= 0.
//      streak reaching CONSEC goes to ALARM; alarm=1 from the same edge.
//    ALARM: alarm held 1; records still pushed, streak still updated.
//      Only rebase or rst exits ALARM.
//  - delta = unsigned absolute difference, full DATA_WIDTH, no wrap (0 vs 255 gives 255).
//    Comparison is strict: delta == thresh gives flag 0.
//  - rebase: next state NO_BASE; streak and alarm cleared at that edge.
//    FIFO and overflow are untouched. If rebase and median_vld coincide, rebase wins
//    and median_in becomes the new baseline (pushed as {median_in, 0, 0}).
//  - Latency: a record pushed on edge N is visible at the FIFO head after edge N when
//    the FIFO was empty. No combinational path from median_vld to out_*.
//  - FIFO:
//    - out_* hold the head record while out_valid=1; out_* are don't-care when empty.
//    - Pop on out_valid & out_ready.
//    - Push and pop in the same cycle are both honoured, even when full.
//    - Push while full without pop: record dropped, overflow <= 1 (cleared only by rst).
//      streak/alarm still update from the dropped result.
//  - median_vld pulses are at least 1 cycle apart (median_calc guarantees this).
//    Back-to-back pulses are accepted every cycle.
// TESTING (DATA_WIDTH=8, CONSEC=3, FIFO_DEPTH=4, thresh=10, out_ready=1 unless stated)
//  1. rst high 5 cycles, then median_vld idle
//     -> out_valid=0, alarm=0, overflow=0, fifo_count=0.
//  2. medians 100, 105, 110, 89
//     -> records (100,0,0), (105,5,0), (110,10,0), (89,11,1) in order; alarm=0.
//  3. after baseline 100: medians 120, 115, 95, 120
//     -> flags 1,1,0,1; alarm stays 0 (streak reset by 95).
//  4. after baseline 100: medians 120, 0, 111
//     -> deltas 20, 100, 11; alarm=1 from the edge of the 3rd pulse.
//     Then 100 -> alarm stays 1.
//  5. out_ready=0, medians 1..6 -> fifo_count=4, overflow=1.
//     Then out_ready=1 -> records for medians 1..4 drain in order, then out_valid=0.
//  6. in ALARM, rebase and median_vld(50) in the same cycle
//     -> alarm=0, record (50,0,0); next median 255 -> delta 205, flag 1.

Source files
------------

// File: rtl/median_drift_monitor.sv
// median_drift_monitor: tracks median drift against a stored baseline.
// It flags deviating results and raises a sticky alarm after CONSEC
// consecutive flags. Each result is queued as a {median, delta, flag} record
// for a valid/ready consumer.
module median_drift_monitor #(
  parameter int DATA_WIDTH = 8,
  parameter int CONSEC     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         median_in,
  input  logic                          median_vld,
  input  logic [DATA_WIDTH-1:0]         thresh,
  input  logic                          rebase,
  output logic [DATA_WIDTH-1:0]         out_median,
  output logic [DATA_WIDTH-1:0]         out_delta,
  output logic                          out_flag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          alarm,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(CONSEC + 1);
  localparam int RW = 2 * DATA_WIDTH + 1;
  localparam logic [SW-1:0] CONSEC_S = SW'(CONSEC);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {NO_BASE, TRACK, ALARM} state_t;

  state_t                state, state_nxt;
  logic [SW-1:0]         streak, streak_nxt;
  logic [DATA_WIDTH-1:0] baseline, baseline_nxt;
  logic [DATA_WIDTH-1:0] delta;
  logic                  flag;
  logic [RW-1:0]         push_rec;

  logic [RW-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  logic                  push, pop, full;

  // State, streak and baseline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= NO_BASE;
      streak   <= '0;
      baseline <= '0;
    end else begin
      state    <= state_nxt;
      streak   <= streak_nxt;
      baseline <= baseline_nxt;
    end
  end

  // Deviation, next-state and record assembly; rebase takes priority and
  // a coincident median becomes the new baseline immediately.
  always_comb begin
    state_nxt    = state;
    streak_nxt   = streak;
    baseline_nxt = baseline;
    delta        = (median_in >= baseline) ? (median_in - baseline)
                                           : (baseline - median_in);
    flag         = delta > thresh;
    push_rec     = {median_in, delta, flag};
    if (rebase || state == NO_BASE) begin
      push_rec   = {median_in, {DATA_WIDTH{1'b0}}, 1'b0};
      streak_nxt = '0;
      state_nxt  = NO_BASE;
      if (median_vld) begin
        baseline_nxt = median_in;
        state_nxt    = TRACK;
      end
    end else if (median_vld) begin
      if (flag)
        streak_nxt = (streak < CONSEC_S) ? streak + 1'b1 : streak;
      else
        streak_nxt = '0;
      if (streak_nxt == CONSEC_S)
        state_nxt = ALARM;
    end
  end

  assign alarm = (state == ALARM);

  assign full = (count == DEPTH_C);
  assign pop  = (count != '0) && out_ready;
  assign push = median_vld && (!full || pop);

  // Record FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (median_vld && full && !pop) overflow <= 1'b1;
    end
  end

  // Record storage (no reset needed; contents qualified by count)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_rec;
  end

  assign out_valid  = (count != '0);
  assign fifo_count = count;
  assign out_median = out_valid ? mem[rd_ptr][RW-1 -: DATA_WIDTH] : '0;
  assign out_delta  = out_valid ? mem[rd_ptr][DATA_WIDTH:1] : '0;
  assign out_flag   = out_valid ? mem[rd_ptr][0] : 1'b0;

endmodule

// File: tb/tb_median_drift_monitor.sv
// Directed testbench for median_drift_monitor (DATA_WIDTH=8, CONSEC=3, FIFO_DEPTH=4).
module tb_median_drift_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] median_in;
  logic       median_vld;
  logic [7:0] thresh;
  logic       rebase;
  logic [7:0] out_median;
  logic [7:0] out_delta;
  logic       out_flag;
  logic       out_valid;
  logic       out_ready;
  logic       alarm;
  logic       overflow;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  median_drift_monitor #(
    .DATA_WIDTH(8),
    .CONSEC(3),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .median_in(median_in), .median_vld(median_vld),
    .thresh(thresh), .rebase(rebase), .out_median(out_median),
    .out_delta(out_delta), .out_flag(out_flag), .out_valid(out_valid),
    .out_ready(out_ready), .alarm(alarm), .overflow(overflow),
    .fifo_count(fifo_count)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input int m, input int d, input int f);
    check({tag, ".valid"},  int'(out_valid), 1);
    check({tag, ".median"}, int'(out_median), m);
    check({tag, ".delta"},  int'(out_delta), d);
    check({tag, ".flag"},   int'(out_flag), f);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input int m, input bit rb = 1'b0);
    median_in  = 8'(m);
    median_vld = 1'b1;
    rebase     = rb;
    step();
    median_vld = 1'b0;
    rebase     = 1'b0;
  endtask

  task automatic do_rebase();
    rebase = 1'b1;
    step();
    rebase = 1'b0;
  endtask

  initial begin
    rst = 1'b1; median_in = '0; median_vld = 1'b0; thresh = 8'd10;
    rebase = 1'b0; out_ready = 1'b1;

    // 1. reset state
    repeat (5) step();
    rst = 1'b0;
    step();
    check("rst.valid", int'(out_valid), 0);
    check("rst.alarm", int'(alarm), 0);
    check("rst.ovf",   int'(overflow), 0);
    check("rst.count", int'(fifo_count), 0);

    // 2. baseline capture, equal-threshold boundary, first flag
    pulse(100); check_head("t2a", 100, 0, 0);
    pulse(105); check_head("t2b", 105, 5, 0);
    pulse(110); check_head("t2c", 110, 10, 0);
    pulse(89);  check_head("t2d", 89, 11, 1);
    check("t2.alarm", int'(alarm), 0);

    // 3. streak broken by an in-range result
    do_rebase();
    pulse(100); check_head("t3base", 100, 0, 0);
    pulse(120); check_head("t3a", 120, 20, 1);
    pulse(115); check_head("t3b", 115, 15, 1);
    pulse(95);  check_head("t3c", 95, 5, 0);
    pulse(120); check_head("t3d", 120, 20, 1);
    check("t3.alarm", int'(alarm), 0);

    // 4. three consecutive flags raise alarm, which then sticks
    do_rebase();
    pulse(100);
    pulse(120); check_head("t4a", 120, 20, 1);
    pulse(0);   check_head("t4b", 0, 100, 1);
    check("t4.alarm_pre", int'(alarm), 0);
    pulse(111); check_head("t4c", 111, 11, 1);
    check("t4.alarm", int'(alarm), 1);
    pulse(100); check_head("t4d", 100, 0, 0);
    check("t4.alarm_held", int'(alarm), 1);
    step();
    check("t4.empty", int'(out_valid), 0);

    // 5. overflow with consumer stalled, then in-order drain
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) pulse(i);
    check("t5.count", int'(fifo_count), 4);
    check("t5.ovf",   int'(overflow), 1);
    out_ready = 1'b1;
    #1;
    for (int i = 1; i <= 4; i++) begin
      check_head("t5drain", i, 100 - i, 1);
      step();
    end
    check("t5.empty", int'(out_valid), 0);
    check("t5.count0", int'(fifo_count), 0);

    // 6. rebase coinciding with a result in ALARM
    check("t6.alarm_pre", int'(alarm), 1);
    pulse(50, 1'b1);
    check("t6.alarm", int'(alarm), 0);
    check_head("t6a", 50, 0, 0);
    pulse(255); check_head("t6b", 255, 205, 1);

    // mid-operation reset discards FIFO and overflow
    out_ready = 1'b0;
    pulse(7);
    rst = 1'b1; step(); rst = 1'b0;
    check("rst2.count", int'(fifo_count), 0);
    check("rst2.ovf",   int'(overflow), 0);

    // push and pop in the same cycle while full
    pulse(10); pulse(20); pulse(30); pulse(40);
    check("full.count", int'(fifo_count), 4);
    out_ready = 1'b1;
    pulse(50);
    check("full.count_pp", int'(fifo_count), 4);
    check("full.ovf",      int'(overflow), 0);
    check_head("full.head", 20, 10, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
